// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the 64-bit timer compare/interrupt stage.
//   - Register offsets of the compare/interrupt registers (TCMP0/TCMP1/TIER/TISR)
//   - Counter width and compare-register reset value
//   - Bit positions of the enable and status flags
//   - merge_lanes(): byte-strobed merge of a 32-bit APB write into a register
// ---------------------------------------------------------------------------
package timer_pkg;

    localparam int          CNT_W           = 64;
    localparam logic [63:0] CMP_RST_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

    localparam logic [7:0]  TCMP0_OFF = 8'h10;
    localparam logic [7:0]  TCMP1_OFF = 8'h14;
    localparam logic [7:0]  TIER_OFF  = 8'h18;
    localparam logic [7:0]  TISR_OFF  = 8'h1C;

    localparam int          INT_EN_BIT = 0;
    localparam int          INT_ST_BIT = 0;

    // Lanes with strb[k]=1 take the new byte, the rest keep the old byte.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_v[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cmp_int_ctrl_if.sv
// ---------------------------------------------------------------------------
// cmp_int_ctrl_if
// APB-side register bus of the timer compare/interrupt stage.
//   wr_CMP0/wr_CMP1/wr_TIER/wr_TISR : one-cycle write strobes per register
//   pstrb, wdata                    : byte strobes and write data
//   cmp_val, int_en, int_st         : register readback from the block
// master = register-bus side (APB decoder), slave = cmp_int_ctrl.
// ---------------------------------------------------------------------------
interface cmp_int_ctrl_if #(
    parameter int DATA_W = 32
) ();
    import timer_pkg::*;

    logic                  wr_CMP0;
    logic                  wr_CMP1;
    logic                  wr_TIER;
    logic                  wr_TISR;
    logic [DATA_W/8-1:0]   pstrb;
    logic [DATA_W-1:0]     wdata;
    logic [CNT_W-1:0]      cmp_val;
    logic                  int_en;
    logic                  int_st;

    modport master (
        output wr_CMP0, wr_CMP1, wr_TIER, wr_TISR, pstrb, wdata,
        input  cmp_val, int_en, int_st
    );

    modport slave (
        input  wr_CMP0, wr_CMP1, wr_TIER, wr_TISR, pstrb, wdata,
        output cmp_val, int_en, int_st
    );

endinterface

// File: rtl/cmp_match_det.sv
// ---------------------------------------------------------------------------
// cmp_match_det
// 64-bit count/compare equality with rising-edge detection, so a count that
// stays equal to the compare value for many cycles yields a single event.
//   clk        : clock
//   rst_n      : synchronous reset, active-low (clears match history)
//   count      : registered counter value
//   cmp_val    : current compare register
//   match_rise : one-cycle pulse on each new match
// ---------------------------------------------------------------------------
module cmp_match_det
    import timer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] count,
    input  logic [CNT_W-1:0] cmp_val,
    output logic             match_rise
);

    logic match;
    logic match_d;
    logic match_q;

    always_comb begin
        match   = (count == cmp_val);
        match_d = match;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    // A compare write landing on the current count is also a new match,
    // because match_q still reflects the previous compare value.
    assign match_rise = match & ~match_q;

endmodule

// File: rtl/cmp_int_ctrl.sv
// ---------------------------------------------------------------------------
// cmp_int_ctrl
// Compare register, interrupt enable and sticky W1C interrupt status of the
// 64-bit timer.
//   clk     : timer/APB clock
//   rst_n   : synchronous reset, active-low
//   bus     : register bus (slave modport): write strobes, pstrb, wdata,
//             readback of cmp_val, int_en, int_st
//   count   : registered counter value from the counter stage
//   tim_int : timer interrupt = int_en & int_st
// ---------------------------------------------------------------------------
module cmp_int_ctrl
    import timer_pkg::*;
#(
    parameter logic [63:0] CMP_RST = CMP_RST_DEFAULT,
    parameter int          DATA_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    cmp_int_ctrl_if.slave    bus,
    input  logic [CNT_W-1:0] count,
    output logic             tim_int
);

    logic [CNT_W-1:0] cmp_val_d, cmp_val_q;
    logic             int_en_d,  int_en_q;
    logic             int_st_d,  int_st_q;
    logic             match_rise;

    cmp_match_det u_match_det (
        .clk        (clk),
        .rst_n      (rst_n),
        .count      (count),
        .cmp_val    (cmp_val_q),
        .match_rise (match_rise)
    );

    always_comb begin
        cmp_val_d = cmp_val_q;
        if (bus.wr_CMP0) begin
            cmp_val_d[DATA_W-1:0] =
                merge_lanes(cmp_val_q[DATA_W-1:0], bus.wdata, bus.pstrb);
        end
        if (bus.wr_CMP1) begin
            cmp_val_d[CNT_W-1:DATA_W] =
                merge_lanes(cmp_val_q[CNT_W-1:DATA_W], bus.wdata, bus.pstrb);
        end
    end

    always_comb begin
        int_en_d = int_en_q;
        if (bus.wr_TIER && bus.pstrb[0]) begin
            int_en_d = bus.wdata[INT_EN_BIT];
        end
    end

    // A new match wins over a same-cycle W1C so no event is ever lost.
    always_comb begin
        int_st_d = int_st_q;
        if (match_rise) begin
            int_st_d = 1'b1;
        end else if (bus.wr_TISR && bus.pstrb[0] && bus.wdata[INT_ST_BIT]) begin
            int_st_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmp_val_q <= CMP_RST;
            int_en_q  <= 1'b0;
            int_st_q  <= 1'b0;
        end else begin
            cmp_val_q <= cmp_val_d;
            int_en_q  <= int_en_d;
            int_st_q  <= int_st_d;
        end
    end

    assign bus.cmp_val = cmp_val_q;
    assign bus.int_en  = int_en_q;
    assign bus.int_st  = int_st_q;
    assign tim_int     = int_en_q & int_st_q;

endmodule

// File: doc/cmp_int_ctrl.md
Name: cmp_int_ctrl

Overview:
Downstream stage of the 64-bit timer counter. It holds the 64-bit compare value (TCMP1:TCMP0), which software writes over APB with byte strobes, and compares it against the live counter value every cycle. It records a sticky interrupt status on each new match and drives the timer interrupt line through a software enable (TIER) and a write-1-to-clear status (TISR).

Parameters:
CMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of the compare register.
DATA_W, 32, APB write-data width. Fixed at 32; byte lanes map to pstrb[3:0].

Ports:
clk  input  1  timer/APB clock.
rst_n  input  1  synchronous reset, active-low.
wr_CMP0  input  1  APB write strobe to TCMP0 (cmp_val[31:0]), one cycle.
wr_CMP1  input  1  APB write strobe to TCMP1 (cmp_val[63:32]), one cycle.
wr_TIER  input  1  APB write strobe to the interrupt-enable register.
wr_TISR  input  1  APB write strobe to the interrupt-status register (W1C).
pstrb  input  4  APB byte strobes; pstrb[k] qualifies wdata[8k+7:8k].
wdata  input  32  APB write data.
count  input  64  registered counter value from the counter stage.
cmp_val  output  64  current compare register, for readback.
int_en  output  1  TIER[0].
int_st  output  1  TISR[0], sticky match status.
tim_int  output  1  timer interrupt = int_en & int_st.

Behaviour:
- All state updates on posedge clk. When rst_n=0 at an edge, the block forces cmp_val=CMP_RST, int_en=0, int_st=0, match_q=0, regardless of simultaneous writes. tim_int is therefore 0 the cycle after reset.
- Compare write, per byte lane:
  - wr_CMP0 & pstrb[k] loads cmp_val[8k+7:8k] from wdata lane k.
  - wr_CMP1 & pstrb[k] loads cmp_val[32+8k+7:32+8k] from wdata lane k.
  - Unstrobed lanes hold their value.
  - wr_CMP0 and wr_CMP1 together in one cycle: both halves are written.
- Match: match = (count == cmp_val), a combinational 64-bit equality on the current register values. match_q <= match every cycle.
- Event detect: match_rise = match & ~match_q.
  - A count that stays equal for many cycles (counter stopped or divided) produces one event only.
  - A compare write that makes cmp_val equal to the current count is a new match, and sets status one cycle later.
- Status:
  - int_st <= 1 when match_rise.
  - Otherwise int_st <= 0 when wr_TISR & pstrb[0] & wdata[0].
  - Otherwise int_st holds.
  - Set has priority over a clear in the same cycle.
  - Writing 0 to TISR has no effect.
- Enable: wr_TIER & pstrb[0] loads int_en <= wdata[0]. Other bits are reserved and ignored.
- Latency:
  - count equals cmp_val during cycle N (with match_q=0), so int_st=1 from cycle N+1.
  - tim_int is combinational from the int_en and int_st registers, so it asserts in cycle N+1 if int_en=1.
  - A W1C in cycle M drops int_st and tim_int in cycle M+1.
- Enabling with a pending status raises tim_int the cycle after the TIER write. Disabling masks tim_int only; int_st keeps recording.
- Wrap-around: the counter wrapping from all-ones to 0 is an ordinary value change. With the default CMP_RST, the match at count=all-ones fires.
- Counter reset or software counter load: the comparator treats a new count value like any other and applies the same edge rule.
- Reset mid-operation clears pending status and the compare value in the same edge.

Decomposition:
- Shared package (timer_pkg):
  - register offset constants: TCMP0/TCMP1/TIER/TISR;
  - CMP_RST default;
  - bit indices INT_EN_BIT=0, INT_ST_BIT=0;
  - counter width constant 64.
- One natural sub-module: cmp_match_det. It holds the 64-bit equality, the match_q register and match_rise, with inputs clk, rst_n, count, cmp_val and output match_rise.
- The register/W1C logic stays in cmp_int_ctrl.

Test Plan:
1. Reset → cmp_val=64'hFFFF_FFFF_FFFF_FFFF, int_en=0, int_st=0, tim_int=0.
2. Byte-strobe write: wr_CMP0 wdata=32'h1122_3344 pstrb=4'b0101, then wr_CMP1 wdata=32'h0000_0000 pstrb=4'hF → cmp_val=64'h0000_0000_FF22_FF44.
3. Match and latency: cmp_val=64'h0000_0000_0000_0010, int_en=1, count steps 0x0E,0x0F,0x10,0x11 → int_st and tim_int go 1 the cycle after count=0x10 and stay 1.
4. Single event on a held count: count held at 0x10 for 8 cycles, W1C in cycle 3 → int_st clears and does not re-assert while count remains 0x10. It re-asserts only after count leaves 0x10 and returns to it.
5. Simultaneous set and clear: match_rise and a TISR write of wdata=1 in the same cycle → int_st=1. TISR write with wdata=0 → no change.
6. Masking and reset: int_st=1 with int_en=0 → tim_int=0. A TIER write of 1 gives tim_int=1 next cycle. Assert rst_n=0 for one edge → int_st=0, int_en=0, cmp_val=all-ones.
